// File: rtl/led_arbiter.sv
// led_arbiter: round-robin owner selection for the single board LED.
// The owner keeps the grant for a minimum hold time and drives the LED from its registered value.
module led_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int HOLD_CYCLES = 8,
    parameter int CNT_W       = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] val,
    output logic [NUM_REQ-1:0] gnt,
    output logic               led,
    output logic               busy
);
    localparam int PW = $clog2(NUM_REQ);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               led_q, led_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [PW-1:0]      own_q, own_d;
    logic [PW-1:0]      win;
    logic               found;

    // First requester at or above ptr, wrapping explicitly so NUM_REQ need not be a power of two.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int idx;
            idx = int'(ptr_q) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        led_d   = led_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        own_d   = own_q;
        if (state_q == IDLE) begin
            if (found) begin
                state_d = HOLD;
                gnt_d   = {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
                led_d   = val[win];
                busy_d  = 1'b1;
                cnt_d   = '0;
                ptr_d   = (win == PW'(NUM_REQ - 1)) ? '0 : win + PW'(1);
                own_d   = win;
            end else begin
                gnt_d  = '0;
                led_d  = 1'b0;
                busy_d = 1'b0;
            end
        end else if (!req[own_q] || (cnt_q == CNT_MAX && (req & ~gnt_q) != '0)) begin
            state_d = IDLE;
            gnt_d   = '0;
            led_d   = 1'b0;
            busy_d  = 1'b0;
            cnt_d   = '0;
        end else begin
            led_d = val[own_q];
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            ptr_q   <= '0;
            own_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            own_q   <= own_d;
        end
    end

    assign gnt  = gnt_q;
    assign led  = led_q;
    assign busy = busy_q;
endmodule

// File: tb/tb_led_arbiter.sv
// tb_led_arbiter: directed vectors queue their expected outputs; a monitor checks every cycle.
module tb_led_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = 4'b1111;
    logic [3:0] val = 4'b0000;
    logic [3:0] gnt;
    logic       led;
    logic       busy;

    logic [5:0] eq[$];
    string      nq[$];
    int         vectors = 0;
    int         miscompares = 0;

    led_arbiter #(.NUM_REQ(4), .HOLD_CYCLES(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .req(req), .val(val), .gnt(gnt), .led(led), .busy(busy)
    );

    always #5 clk = ~clk;

    // Inputs change on negedge; the response is visible after the following posedge.
    task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] v,
                        input logic [3:0] g, input logic l, input string n);
        @(negedge clk);
        rst = r;
        req = rq;
        val = v;
        eq.push_back({g, l, |g});
        nq.push_back(n);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (eq.size() != 0) begin
                logic [5:0] e;
                string n;
                e = eq.pop_front();
                n = nq.pop_front();
                vectors++;
                if ({gnt, led, busy} !== e) begin
                    miscompares++;
                    $display("FAIL %s: got gnt=%b led=%b busy=%b, expected gnt=%b led=%b busy=%b",
                             n, gnt, led, busy, e[5:2], e[1], e[0]);
                end
            end
        end
    end

    initial begin
        logic [3:0] vr;
        logic       v1;
        vr = 4'b1010;
        step(0, 4'b1111, 4'b0000, 4'b0000, 0, "reset0");
        step(0, 4'b1111, 4'b0000, 4'b0000, 0, "reset1");
        step(1, 4'b0100, 4'b0100, 4'b0100, 1, "first_grant");
        step(1, 4'b0000, 4'b0100, 4'b0000, 0, "drop_release");
        step(0, 4'b0000, 4'b0000, 4'b0000, 0, "reset_rr");
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 8; c++) step(1, 4'b1111, vr, 4'(1 << k), vr[k], "rotation_hold");
            step(1, 4'b1111, vr, 4'b0000, 0, "rotation_bubble");
        end
        step(1, 4'b1111, vr, 4'b0001, 0, "rotation_wrap");
        step(0, 4'b0000, 4'b0000, 4'b0000, 0, "reset_early");
        step(1, 4'b0001, 4'b0000, 4'b0001, 0, "early_grant");
        step(1, 4'b0011, 4'b0000, 4'b0001, 0, "early_held2");
        step(1, 4'b0011, 4'b0000, 4'b0001, 0, "early_held3");
        step(1, 4'b0010, 4'b0000, 4'b0000, 0, "early_release");
        step(1, 4'b0010, 4'b0000, 4'b0010, 0, "early_next");
        step(0, 4'b0000, 4'b0000, 4'b0000, 0, "reset_sole");
        for (int c = 0; c < 30; c++) step(1, 4'b0001, 4'b0001, 4'b0001, 1, "sole_owner");
        step(0, 4'b0000, 4'b0000, 4'b0000, 0, "reset_follow");
        step(1, 4'b0010, 4'b0000, 4'b0010, 0, "follow_grant");
        for (int c = 0; c < 10; c++) begin
            v1 = (c % 2) == 0;
            step(1, 4'b0010, v1 ? 4'b0010 : 4'b0101, 4'b0010, v1, "led_follow");
        end
        step(0, 4'b0000, 4'b0000, 4'b0000, 0, "reset_mid");
        step(1, 4'b0100, 4'b0000, 4'b0100, 0, "mid_cnt0");
        for (int c = 0; c < 3; c++) step(1, 4'b0100, 4'b0000, 4'b0100, 0, "mid_hold");
        step(0, 4'b0100, 4'b0000, 4'b0000, 0, "mid_reset");
        step(1, 4'b1111, 4'b0000, 4'b0001, 0, "ptr_restored");
        @(posedge clk);
        #2;
        if (eq.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending vectors, expected 0", eq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
